constant_encoder: RTL and testbench
===================================

CONSTANT_ENCODER -- requirements
Module: constant_encoder

Interface
REQ-001 SHALL have port MCLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port RSTn, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have port in_valid, input, 1 bit: a request is present on the in_* fields.
REQ-004 SHALL have port in_ready, output, 1 bit: the encoder can accept a request.
REQ-005 SHALL have port in_op, input, 4 bits: two-operand opcode, placed in IW[15:12].
REQ-006 SHALL have port in_bw, input, 1 bit: byte operation, placed in IW[6].
REQ-007 SHALL have port in_imm, input, 16 bits: immediate source value.
REQ-008 SHALL have port in_dst, input, 4 bits: destination register, placed in IW[3:0].
REQ-009 SHALL have port in_ad, input, 1 bit: destination addressing mode, placed in IW[7].
REQ-010 SHALL have port in_didx, input, 16 bits: destination index word, used only when in_ad=1.
REQ-011 SHALL have port out_valid, output, 1 bit: out_word holds a valid word.
REQ-012 SHALL have port out_ready, input, 1 bit: the consumer accepts out_word.
REQ-013 SHALL have port out_word, output, 16 bits: instruction or extension word.
REQ-014 SHALL have port out_last, output, 1 bit: the current word is the final word of the instruction.
REQ-015 SHALL have port err, output, 1 bit: one-cycle pulse when a request is rejected.

Function
REQ-016 SHALL accept a request on a cycle where in_valid=1 and in_ready=1, capturing all in_* fields into registers.
REQ-017 SHALL implement states IDLE, EMIT_IW, EMIT_SRC and EMIT_DST, with in_ready=1 only in IDLE and only while RSTn is high.
REQ-018 SHALL produce IW = {op, srcReg, ad, bw, As, dst}.
REQ-019 SHALL select the source encoding from the compare value, in priority order:
- 0 -> R3, As=00
- 1 -> R3, As=01
- 2 -> R3, As=10
- all-ones -> R3, As=11
- 4 -> R2, As=10
- 8 -> R2, As=11
- otherwise -> R0, As=11 (immediate), with a source extension word equal to in_imm.
REQ-020 SHALL use in_imm[7:0] as the compare value when bw=1, so that 0x00FF maps to all-ones; when bw=0 it SHALL compare all 16 bits.
REQ-021 SHALL emit words in the order IW, then the source extension word (if any), then in_didx (if ad=1); out_last SHALL be 1 only on the final word.
REQ-022 SHALL assert out_valid in the cycle after acceptance (latency 1), with IW on out_word.
REQ-023 SHALL advance to the next word only on a cycle where out_valid=1 and out_ready=1; after the last word is accepted it SHALL return to IDLE.
REQ-024 SHALL hold out_word and out_last stable while out_valid=1 and out_ready=0.
REQ-025 SHALL NOT support back-to-back acceptance; the earliest next acceptance is the cycle after the last handshake.
REQ-026 SHALL treat in_op in 0x0-0x3 (not a two-operand opcode) as follows:
- the request is still accepted;
- err pulses for 1 cycle in the following cycle;
- no words are emitted and the state stays in IDLE.
REQ-027 SHALL give a request with in_valid=0 no effect; in_* values in non-IDLE states SHALL be ignored.

Reset
REQ-028 SHALL, while RSTn=0 (asynchronous):
- force state to IDLE;
- force out_valid=0, out_word=0x0000, out_last=0, err=0, in_ready=0;
- discard any partially emitted instruction.
REQ-029 SHALL have in_ready=1 on the first cycle after RSTn is released.

Verification
REQ-030 SHALL cover MOV #0,R5: op=4, imm=0x0000, dst=5, ad=0, bw=0 -> one word 0x4305 with out_last=1.
REQ-031 SHALL cover MOV #8,R5 -> 0x4235 with last=1; and MOV.B #0xFF,R5 (bw=1) -> 0x4375 with last=1.
REQ-032 SHALL cover ADD #5,R6: op=5, imm=0x0005 -> 0x5036, then 0x0005 with last=1.
REQ-033 SHALL cover MOV #0x1234,2(R7): ad=1, didx=0x0002 -> 0x40B7, 0x1234, then 0x0002 with last=1.
REQ-034 SHALL cover backpressure: out_ready=0 for 5 cycles during word 2 of REQ-033 -> word 0x1234 held stable; after release, 0x0002 is emitted next.
REQ-035 SHALL cover reset mid-instruction: RSTn low during EMIT_SRC -> out_valid=0 immediately; after release, in_ready=1, and op=0x2 is accepted with err pulsing once and no output.

Source files
------------

// File: rtl/constant_encoder.sv
// Two-operand instruction encoder: folds an immediate into the constant-generator
// registers when possible, then streams IW / source ext / dest index over a valid-ready port.
module constant_encoder (
    input  logic        MCLK,
    input  logic        RSTn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_op,
    input  logic        in_bw,
    input  logic [15:0] in_imm,
    input  logic [3:0]  in_dst,
    input  logic        in_ad,
    input  logic [15:0] in_didx,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_word,
    output logic        out_last,
    output logic        err
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] EMIT_IW  = 2'd1;
    localparam logic [1:0] EMIT_SRC = 2'd2;
    localparam logic [1:0] EMIT_DST = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [15:0] iw_q, src_q, didx_q;
    logic        has_src_q, ad_q, err_q;

    logic [15:0] cmp;
    logic        all_ones;
    logic [3:0]  sreg;
    logic [1:0]  as_mode;
    logic        use_ext;
    logic        accept, illegal, hs;

    assign in_ready  = (state_q == IDLE) && RSTn;
    assign accept    = in_valid && in_ready;
    assign illegal   = (in_op < 4'd4);
    assign out_valid = (state_q != IDLE);
    assign hs        = out_valid && out_ready;
    assign err       = err_q;

    // Byte ops compare only the low byte, so 0x??FF counts as all-ones (-1).
    always_comb begin
        cmp      = in_bw ? {8'h00, in_imm[7:0]} : in_imm;
        all_ones = in_bw ? (in_imm[7:0] == 8'hFF) : (in_imm == 16'hFFFF);
        sreg     = 4'd0;
        as_mode  = 2'b11;
        use_ext  = 1'b1;
        if (cmp == 16'd0) begin
            sreg = 4'd3; as_mode = 2'b00; use_ext = 1'b0;
        end else if (cmp == 16'd1) begin
            sreg = 4'd3; as_mode = 2'b01; use_ext = 1'b0;
        end else if (cmp == 16'd2) begin
            sreg = 4'd3; as_mode = 2'b10; use_ext = 1'b0;
        end else if (all_ones) begin
            sreg = 4'd3; as_mode = 2'b11; use_ext = 1'b0;
        end else if (cmp == 16'd4) begin
            sreg = 4'd2; as_mode = 2'b10; use_ext = 1'b0;
        end else if (cmp == 16'd8) begin
            sreg = 4'd2; as_mode = 2'b11; use_ext = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (accept && !illegal) state_d = EMIT_IW;
            EMIT_IW:  if (hs) state_d = has_src_q ? EMIT_SRC : (ad_q ? EMIT_DST : IDLE);
            EMIT_SRC: if (hs) state_d = ad_q ? EMIT_DST : IDLE;
            EMIT_DST: if (hs) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        out_word = 16'h0000;
        out_last = 1'b0;
        case (state_q)
            EMIT_IW:  begin out_word = iw_q;   out_last = !has_src_q && !ad_q; end
            EMIT_SRC: begin out_word = src_q;  out_last = !ad_q;               end
            EMIT_DST: begin out_word = didx_q; out_last = 1'b1;                end
            default:  begin out_word = 16'h0000; out_last = 1'b0;              end
        endcase
    end

    always_ff @(posedge MCLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q   <= IDLE;
            iw_q      <= 16'h0000;
            src_q     <= 16'h0000;
            didx_q    <= 16'h0000;
            has_src_q <= 1'b0;
            ad_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= accept && illegal;
            if (accept) begin
                iw_q      <= {in_op, sreg, in_ad, in_bw, as_mode, in_dst};
                src_q     <= in_imm;
                didx_q    <= in_didx;
                has_src_q <= use_ext;
                ad_q      <= in_ad;
            end
        end
    end

endmodule

// File: tb/tb_constant_encoder.sv
// Bench for constant_encoder: directed encodings, backpressure, reset mid-instruction
// and randomized requests checked against an arithmetic model of the encoding rules.
module tb_constant_encoder;

    logic        MCLK = 1'b0;
    logic        RSTn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_op = 4'd0;
    logic        in_bw = 1'b0;
    logic [15:0] in_imm = 16'h0;
    logic [3:0]  in_dst = 4'd0;
    logic        in_ad = 1'b0;
    logic [15:0] in_didx = 16'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_word;
    logic        out_last;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] exp_w [0:2];
    int          exp_n;
    logic [15:0] got_w [0:7];
    logic        got_l [0:7];
    int          got_n;
    int          stab_err;
    int          tmo;

    always #5 MCLK = ~MCLK;

    constant_encoder dut (
        .MCLK(MCLK), .RSTn(RSTn),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_bw(in_bw), .in_imm(in_imm), .in_dst(in_dst),
        .in_ad(in_ad), .in_didx(in_didx),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_word(out_word), .out_last(out_last), .err(err)
    );

    // Expected word stream computed straight from the constant-generator table.
    task automatic model(input int op, input int bw, input int imm, input int dst,
                         input int ad, input int didx);
        int cv, ones, sr, as_m, ext;
        cv   = bw ? (imm % 256) : imm;
        ones = bw ? 255 : 65535;
        ext  = 0;
        if      (cv == 0)    begin sr = 3; as_m = 0; end
        else if (cv == 1)    begin sr = 3; as_m = 1; end
        else if (cv == 2)    begin sr = 3; as_m = 2; end
        else if (cv == ones) begin sr = 3; as_m = 3; end
        else if (cv == 4)    begin sr = 2; as_m = 2; end
        else if (cv == 8)    begin sr = 2; as_m = 3; end
        else                 begin sr = 0; as_m = 3; ext = 1; end
        exp_n = 0;
        if (op < 4) return;
        exp_w[0] = 16'(op * 4096 + sr * 256 + ad * 128 + bw * 64 + as_m * 16 + dst);
        exp_n = 1;
        if (ext != 0) begin exp_w[exp_n] = 16'(imm); exp_n++; end
        if (ad != 0)  begin exp_w[exp_n] = 16'(didx); exp_n++; end
    endtask

    // Present one request; returns at the negedge one cycle after acceptance.
    task automatic send(input int op, input int bw, input int imm, input int dst,
                        input int ad, input int didx, output int ok);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge MCLK);
            if (in_ready) begin ok = 1; break; end
        end
        if (ok == 0) return;
        in_valid = 1'b1;
        in_op = 4'(op); in_bw = 1'(bw); in_imm = 16'(imm);
        in_dst = 4'(dst); in_ad = 1'(ad); in_didx = 16'(didx);
        @(negedge MCLK);
        in_valid = 1'b0;
        in_op = 4'($urandom); in_bw = 1'($urandom); in_imm = 16'($urandom);
        in_dst = 4'($urandom); in_ad = 1'($urandom); in_didx = 16'($urandom);
    endtask

    // Drains words with random out_ready, recording hold violations under stall.
    task automatic collect(input int rdy_pct);
        logic        pv, pr, pl;
        logic [15:0] pw;
        pv = 1'b0; pr = 1'b0; pw = 16'h0; pl = 1'b0;
        got_n = 0; stab_err = 0; tmo = 1;
        for (int c = 0; c < 200; c++) begin
            if (pv && !pr && (!out_valid || out_word !== pw || out_last !== pl)) stab_err++;
            out_ready = ($urandom_range(99) < rdy_pct);
            pv = out_valid; pr = out_ready; pw = out_word; pl = out_last;
            if (out_valid && out_ready && got_n < 8) begin
                got_w[got_n] = out_word; got_l[got_n] = out_last; got_n++;
                if (out_last) begin
                    @(negedge MCLK);
                    out_ready = 1'b0;
                    tmo = 0;
                    return;
                end
            end
            @(negedge MCLK);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        RSTn = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || out_word !== 16'h0 || out_last !== 1'b0 ||
            err !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: valid=%b word=%h last=%b err=%b ready=%b, want all zero",
                     out_valid, out_word, out_last, err, in_ready);
        end
        repeat (2) @(negedge MCLK);
        RSTn = 1'b1;
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: in_ready=%b want 1", in_ready);
        end
    endtask

    task automatic test_directed;
        int tab [0:3][0:5];
        int ok;
        tab[0] = '{4, 0, 16'h0000, 5, 0, 0};
        tab[1] = '{4, 0, 16'h0008, 5, 0, 0};
        tab[2] = '{4, 1, 16'h00FF, 5, 0, 0};
        tab[3] = '{5, 0, 16'h0005, 6, 0, 0};
        for (int t = 0; t < 4; t++) begin
            model(tab[t][0], tab[t][1], tab[t][2], tab[t][3], tab[t][4], tab[t][5]);
            send(tab[t][0], tab[t][1], tab[t][2], tab[t][3], tab[t][4], tab[t][5], ok);
            n_tests++;
            if (!(ok == 1 && out_valid === 1'b1 && out_word === exp_w[0])) begin
                n_fail++;
                $display("FAIL directed%0d_latency: ok=%0d valid=%b word=%h want valid=1 word=%h",
                         t, ok, out_valid, out_word, exp_w[0]);
            end
            collect(100);
            n_tests++;
            if (tmo != 0 || got_n != exp_n) begin
                n_fail++;
                $display("FAIL directed%0d_count: got %0d words (tmo=%0d) want %0d", t, got_n, tmo, exp_n);
            end else begin
                for (int k = 0; k < exp_n; k++) begin
                    n_tests++;
                    if (got_w[k] !== exp_w[k] || got_l[k] !== (k == exp_n - 1)) begin
                        n_fail++;
                        $display("FAIL directed%0d_word%0d: got %h last=%b want %h last=%b",
                                 t, k, got_w[k], got_l[k], exp_w[k], (k == exp_n - 1));
                    end
                end
            end
        end
    endtask

    task automatic test_backpressure;
        int ok;
        model(4, 0, 16'h1234, 7, 1, 16'h0002);
        send(4, 0, 16'h1234, 7, 1, 16'h0002, ok);
        n_tests++;
        if (ok != 1 || out_valid !== 1'b1 || out_word !== 16'h40B7 || out_last !== 1'b0 ||
            exp_w[0] !== 16'h40B7) begin
            n_fail++;
            $display("FAIL bp_iw: ok=%0d valid=%b word=%h last=%b want 1 40b7 0", ok, out_valid, out_word, out_last);
        end
        out_ready = 1'b1;
        @(negedge MCLK);
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            n_tests++;
            if (out_valid !== 1'b1 || out_word !== exp_w[1] || out_last !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold%0d: valid=%b word=%h last=%b want 1 %h 0", c, out_valid, out_word, out_last, exp_w[1]);
            end
            @(negedge MCLK);
        end
        out_ready = 1'b1;
        n_tests++;
        if (out_word !== 16'h1234) begin
            n_fail++;
            $display("FAIL bp_release_word: got %h want 1234", out_word);
        end
        @(negedge MCLK);
        n_tests++;
        if (out_valid !== 1'b1 || out_word !== exp_w[2] || out_last !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_didx: valid=%b word=%h last=%b want 1 %h 1", out_valid, out_word, out_last, exp_w[2]);
        end
        @(negedge MCLK);
        out_ready = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_idle: valid=%b ready=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid;
        int ok;
        send(4, 0, 16'h1234, 7, 1, 16'h0002, ok);
        out_ready = 1'b1;
        @(negedge MCLK);
        out_ready = 1'b0;
        n_tests++;
        if (out_valid !== 1'b1 || out_word !== 16'h1234) begin
            n_fail++;
            $display("FAIL rst_mid_src: valid=%b word=%h want 1 1234", out_valid, out_word);
        end
        #2 RSTn = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || out_word !== 16'h0 || in_ready !== 1'b0 || out_last !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_async: valid=%b word=%h ready=%b last=%b want 0 0000 0 0",
                     out_valid, out_word, in_ready, out_last);
        end
        @(negedge MCLK);
        RSTn = 1'b1;
        #1;
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_release: ready=%b valid=%b want 1 0", in_ready, out_valid);
        end
        send(2, 0, 16'h0005, 3, 0, 0, ok);
        n_tests++;
        if (ok != 1 || err !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_err: ok=%0d err=%b valid=%b want 1 1 0", ok, err, out_valid);
        end
        @(negedge MCLK);
        n_tests++;
        if (err !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL illegal_after: err=%b valid=%b ready=%b want 0 0 1", err, out_valid, in_ready);
        end
    endtask

    task automatic test_random;
        int op, bw, imm, dst, ad, didx, ok, sel;
        for (int r = 0; r < 60; r++) begin
            op   = $urandom_range(15);
            bw   = $urandom_range(1);
            dst  = $urandom_range(15);
            ad   = $urandom_range(1);
            didx = $urandom_range(65535);
            sel  = $urandom_range(9);
            case (sel)
                0: imm = 0;      1: imm = 1;      2: imm = 2;
                3: imm = 4;      4: imm = 8;      5: imm = 65535;
                6: imm = $urandom_range(255) * 256 + 255;
                default: imm = $urandom_range(65535);
            endcase
            model(op, bw, imm, dst, ad, didx);
            send(op, bw, imm, dst, ad, didx, ok);
            if (exp_n == 0) begin
                n_tests++;
                if (ok != 1 || err !== 1'b1 || out_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rand%0d_illegal: ok=%0d err=%b valid=%b want 1 1 0", r, ok, err, out_valid);
                end
                @(negedge MCLK);
                continue;
            end
            n_tests++;
            if (ok != 1 || err !== 1'b0 || out_valid !== 1'b1 || out_word !== exp_w[0]) begin
                n_fail++;
                $display("FAIL rand%0d_iw: ok=%0d err=%b valid=%b word=%h want 0 1 %h",
                         r, ok, err, out_valid, out_word, exp_w[0]);
            end
            collect($urandom_range(30, 100));
            n_tests++;
            if (tmo != 0 || got_n != exp_n || stab_err != 0) begin
                n_fail++;
                $display("FAIL rand%0d_stream: words=%0d tmo=%0d holdviol=%0d want %0d 0 0",
                         r, got_n, tmo, stab_err, exp_n);
            end else begin
                for (int k = 0; k < exp_n; k++) begin
                    n_tests++;
                    if (got_w[k] !== exp_w[k] || got_l[k] !== (k == exp_n - 1)) begin
                        n_fail++;
                        $display("FAIL rand%0d_word%0d: got %h last=%b want %h last=%b",
                                 r, k, got_w[k], got_l[k], exp_w[k], (k == exp_n - 1));
                    end
                end
            end
            repeat ($urandom_range(2)) @(negedge MCLK);
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_backpressure;
        test_reset_mid;
        test_random;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
